// File: rtl/uram_loader.sv
// ---------------------------------------------------------------------------
// uram_loader
//
// Upstream feeder for the wide URAM loader. Host words of IN_LEN bits arrive
// over a valid/ready handshake and are serialised into DIN_LEN-bit chunks,
// least-significant chunk first, on we/din/din_valid. One start sequences a
// complete table load of NUM_ROWS rows of DATA_LEN bits. After the last chunk,
// we stays high for DRAIN_CYCLES cycles so the downstream row write can finish.
// Then we drops and done pulses for one cycle.
//
// Ports
//   clk        in   1        clock
//   rst        in   1        asynchronous, active-high reset
//   start      in   1        pulse: begin a load (ignored unless idle)
//   abort      in   1        level: cancel the load in progress
//   s_data     in   IN_LEN   host word
//   s_valid    in   1        s_data valid
//   s_ready    out  1        word accepted when s_valid & s_ready
//   we         out  1        write-enable window to the URAM loader
//   din        out  DIN_LEN  chunk (driven to 0 while we=0)
//   din_valid  out  1        din valid (only while we=1)
//   busy       out  1        a load is in progress
//   done       out  1        one-cycle pulse at load completion
// ---------------------------------------------------------------------------
module uram_loader #(
    parameter int ADDR_LEN     = 9,
    parameter int DATA_LEN     = 128,
    parameter int DIN_LEN      = 8,
    parameter int IN_LEN       = 32,
    parameter int NUM_ROWS     = 512,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [IN_LEN-1:0]  s_data,
    input  logic               s_valid,
    output logic               s_ready,
    output logic               we,
    output logic [DIN_LEN-1:0] din,
    output logic               din_valid,
    output logic               busy,
    output logic               done
);

    localparam int CHUNKS_PER_WORD = IN_LEN / DIN_LEN;
    localparam int TOTAL_CHUNKS    = NUM_ROWS * DATA_LEN / DIN_LEN;
    localparam int TOTAL_WORDS     = TOTAL_CHUNKS / CHUNKS_PER_WORD;
    localparam int MAX_ROWS        = 2 ** ADDR_LEN;

    localparam int CHUNK_W = $clog2(TOTAL_CHUNKS + 1);
    localparam int WORD_W  = (TOTAL_WORDS > 1) ? $clog2(TOTAL_WORDS + 1) : 1;
    // Remaining-chunk counter only has to hold CHUNKS_PER_WORD-1.
    localparam int REM_W   = (CHUNKS_PER_WORD > 1) ? $clog2(CHUNKS_PER_WORD) : 1;
    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [CHUNK_W-1:0] LAST_CHUNK_IDX = CHUNK_W'(TOTAL_CHUNKS - 1);
    localparam logic [WORD_W-1:0]  WORD_LIMIT     = WORD_W'(TOTAL_WORDS);
    localparam logic [REM_W-1:0]   REM_RELOAD     = REM_W'(CHUNKS_PER_WORD - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST     =
        (DRAIN_CYCLES > 0) ? DRAIN_W'(DRAIN_CYCLES - 1) : '0;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0] S_AFTER_LOAD = (DRAIN_CYCLES > 0) ? S_DRAIN : S_DONE;

    // Elaboration-time parameter sanity checks.
    if (DATA_LEN % DIN_LEN != 0) begin : g_bad_data_len
        $error("DATA_LEN must be a multiple of DIN_LEN");
    end
    if (IN_LEN % DIN_LEN != 0) begin : g_bad_in_len
        $error("IN_LEN must be a multiple of DIN_LEN");
    end
    if ((NUM_ROWS * DATA_LEN) % IN_LEN != 0) begin : g_bad_total
        $error("NUM_ROWS*DATA_LEN must be a multiple of IN_LEN");
    end
    if (NUM_ROWS < 1 || NUM_ROWS > MAX_ROWS) begin : g_bad_rows
        $error("NUM_ROWS must lie in 1..2**ADDR_LEN");
    end

    logic [1:0]         state;
    logic [IN_LEN-1:0]  shreg;      // chunks of the current word not yet shown on din
    logic [REM_W-1:0]   rem;        // number of chunks still waiting in shreg
    logic [DIN_LEN-1:0] din_q;
    logic [WORD_W-1:0]  word_cnt;   // words accepted this load
    logic [CHUNK_W-1:0] chunk_cnt;  // chunks shown on din this load (before this cycle)
    logic [DRAIN_W-1:0] drain_cnt;

    logic accept;
    logic last_chunk;

    // The chunk on din this cycle is the last one of its word whenever rem is
    // zero, so the next word can be taken in the same cycle and the chunk
    // stream stays gap-free under a continuous s_valid.
    assign s_ready    = (state == S_LOAD) && !abort && (rem == '0) && (word_cnt < WORD_LIMIT);
    assign accept     = s_valid && s_ready;
    assign last_chunk = din_valid && (chunk_cnt == LAST_CHUNK_IDX);

    assign we   = (state == S_LOAD) || (state == S_DRAIN);
    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);
    assign din  = we ? din_q : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            shreg     <= '0;
            rem       <= '0;
            din_q     <= '0;
            din_valid <= 1'b0;
            word_cnt  <= '0;
            chunk_cnt <= '0;
            drain_cnt <= '0;
        end else if (abort && state != S_IDLE) begin
            // Cancel: drop the buffered word and return to idle without done.
            state     <= S_IDLE;
            shreg     <= '0;
            rem       <= '0;
            din_q     <= '0;
            din_valid <= 1'b0;
            word_cnt  <= '0;
            chunk_cnt <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    din_valid <= 1'b0;
                    if (start && !abort) begin
                        state     <= S_LOAD;
                        shreg     <= '0;
                        rem       <= '0;
                        din_q     <= '0;
                        word_cnt  <= '0;
                        chunk_cnt <= '0;
                        drain_cnt <= '0;
                    end
                end

                S_LOAD: begin
                    if (accept) begin
                        // The first chunk goes straight to din; the rest wait in shreg.
                        din_q     <= s_data[DIN_LEN-1:0];
                        shreg     <= s_data >> DIN_LEN;
                        rem       <= REM_RELOAD;
                        din_valid <= 1'b1;
                        word_cnt  <= word_cnt + 1'b1;
                    end else if (rem != '0) begin
                        din_q     <= shreg[DIN_LEN-1:0];
                        shreg     <= shreg >> DIN_LEN;
                        rem       <= rem - 1'b1;
                        din_valid <= 1'b1;
                    end else begin
                        // Bubble: din keeps its last value.
                        din_valid <= 1'b0;
                    end

                    if (din_valid) begin
                        chunk_cnt <= chunk_cnt + 1'b1;
                    end

                    if (last_chunk) begin
                        state     <= S_AFTER_LOAD;
                        din_valid <= 1'b0;
                        drain_cnt <= '0;
                    end
                end

                S_DRAIN: begin
                    din_valid <= 1'b0;
                    if (drain_cnt == DRAIN_LAST) begin
                        state <= S_DONE;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end

                default: begin
                    // S_DONE: done is high for exactly this one cycle.
                    state     <= S_IDLE;
                    din_valid <= 1'b0;
                    din_q     <= '0;
                end
            endcase
        end
    end

endmodule
